mode_input_conditioner: RTL and testbench
=========================================

# mode_input_conditioner

Input front-end that drives `select_action`. It synchronizes the board switches into `SW` and turns two debounced push buttons into next/previous steps through the `opr_mode_t` operation modes, producing the registered `SELECTOR`. All asynchronous board inputs enter the clock domain here. Nothing downstream sees raw switch or button levels.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of every input synchronizer; minimum 2.
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz). Benches override it to 4.

Ports:
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low. Assertion clears state immediately; release is sampled on `clk`.
- `BTN_NEXT` in 1: raw, asynchronous, bouncing button; active-high.
- `BTN_PREV` in 1: raw, asynchronous, bouncing button; active-high.
- `SW_IN` in `word_t` (16): raw, asynchronous switch bank.
- `SELECTOR` out `opr_mode_t`: registered current operation mode. Feeds `select_action.SELECTOR`.
- `SW` out `word_t` (16): synchronized switch value. Feeds `select_action.SW`.
- `MODE_CHANGED` out 1: one-cycle pulse in the cycle `SELECTOR` takes a new value.

## Operation
- **Reset values** (while `rst_n`=0):
  - `SELECTOR`: `ADD`, the first enumerator.
  - `SW`: 16'h0000.
  - `MODE_CHANGED`: 0.
  - Synchronizer flops, debounce counters and debounced levels: 0.
- **Switch path:** `SW_IN` passes through a `SYNC_STAGES`-deep per-bit synchronizer. The last stage is `SW`. Switches are not debounced.
- **Button path:** each button has its own `SYNC_STAGES` synchronizer followed by a debouncer.
  - The debouncer holds a debounced level `db` and a counter.
  - While the synchronized input equals `db`, the counter is 0.
  - While the input differs from `db`, the counter increments each cycle. Any cycle where it matches `db` again resets the counter to 0.
  - When the counter reaches `DB_CYCLES`-1 with the input still different, `db` takes the input value and the counter clears.
  - A 0->1 transition of `db` produces a one-cycle step pulse. A 1->0 transition produces nothing.
- **Mode stepping:**
  - A next pulse alone sets `SELECTOR` to the next enumerator in declaration order; from the last enumerator it wraps to the first.
  - A prev pulse alone sets `SELECTOR` to the previous enumerator; from the first it wraps to the last.
  - Next and prev pulses in the same cycle: no change, and `MODE_CHANGED` stays 0.
  - `MODE_CHANGED` is 1 exactly in the cycle `SELECTOR` is updated.
- **Held buttons:** a button held down produces one step only. A further step requires a debounced release followed by a debounced press.
- **Reset mid-operation:** any partial debounce count is discarded. A button still held when `rst_n` releases is debounced to 1 and produces one step after the normal latency.

## Timing
- **SW latency:** a change on `SW_IN` appears on `SW` after `SYNC_STAGES` rising edges, ±1 edge depending on the async sampling point.
- **Button latency:** a clean press held steadily updates `SELECTOR` (and pulses `MODE_CHANGED`) `SYNC_STAGES` + `DB_CYCLES` + 1 edges after the input is first sampled high.
- **Glitch rejection:** a high or low glitch that lasts fewer than `DB_CYCLES` synchronized cycles never changes `db`.
- **Output behaviour:** outputs are purely registered, with no combinational path from input to output. `SELECTOR` never holds a value outside `opr_mode_t`.

## Structure
- **Shared package:** `word_t` and `opr_mode_t` stay in `types_pkg`. Add to `types_pkg`:
  - `OPR_MODE_FIRST` and `OPR_MODE_LAST` constants.
  - `opr_mode_next()` and `opr_mode_prev()` functions with the wrap behaviour above, so other stages reuse them.
- **Sub-module:** `btn_debounce`, one instance per button. Ports: `clk`, `rst_n`, raw input. Parameters: `SYNC_STAGES`, `DB_CYCLES`. Outputs: `db` level and `rise` pulse. Its counter width is `$clog2(DB_CYCLES)`.
- **Top level:** holds the `SW` synchronizer and the mode register.

## Test plan
All scenarios use `DB_CYCLES`=4 and `SYNC_STAGES`=2.
- **Reset:** assert `rst_n`=0 mid-cycle -> `SELECTOR`=`ADD`, `SW`=0 and `MODE_CHANGED`=0 immediately, without waiting for a clock edge.
- **Switch sync:** `SW_IN`=16'hA5A5 -> `SW`=16'hA5A5 two edges later. No other output changes.
- **Clean next press:** hold `BTN_NEXT` high for 20 cycles -> `SELECTOR`=successor of `ADD` 7 edges after the sample, `MODE_CHANGED` exactly one pulse, and no second step while held.
- **Bounce and glitch:** a 3-cycle pulse on `BTN_NEXT`, then toggling 1/0 every cycle for 10 cycles -> `SELECTOR` unchanged, `MODE_CHANGED` never 1.
- **Prev wrap and simultaneous press:** prev from reset -> `SELECTOR`=last enumerator. `BTN_NEXT` and `BTN_PREV` pressed together with identical timing -> no change, no pulse.
- **Reset during debounce:** `rst_n` low for 2 cycles while `BTN_PREV` is 2 cycles into debounce, button released before `rst_n` rises -> no step after reset, `SELECTOR`=`ADD`.

Source files
------------

// File: rtl/types_pkg.sv
// Shared datapath types for the calculator pipeline: switch word and operation modes,
// plus wrap-around stepping helpers reused by every stage that walks the mode list.
package types_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    LAND = 3'd2,
    LOR  = 3'd3,
    LXOR = 3'd4,
    SLT  = 3'd5
  } opr_mode_t;

  localparam opr_mode_t OPR_MODE_FIRST = ADD;
  localparam opr_mode_t OPR_MODE_LAST  = SLT;

  // Successor in declaration order; the last mode wraps to the first, and any
  // unexpected encoding recovers to the first mode.
  function automatic opr_mode_t opr_mode_next(input opr_mode_t m);
    opr_mode_t r;
    case (m)
      ADD:     r = SUB;
      SUB:     r = LAND;
      LAND:    r = LOR;
      LOR:     r = LXOR;
      LXOR:    r = SLT;
      SLT:     r = ADD;
      default: r = OPR_MODE_FIRST;
    endcase
    return r;
  endfunction

  // Predecessor in declaration order; the first mode wraps to the last.
  function automatic opr_mode_t opr_mode_prev(input opr_mode_t m);
    opr_mode_t r;
    case (m)
      ADD:     r = SLT;
      SUB:     r = ADD;
      LAND:    r = SUB;
      LOR:     r = LAND;
      LXOR:    r = LOR;
      SLT:     r = LXOR;
      default: r = OPR_MODE_FIRST;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mode_input_conditioner_btn_debounce.sv
// Push-button front end: synchronizer chain followed by a counting debouncer that
// emits a one-cycle pulse on each accepted press (release is silent).
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   db_r;
  logic                   db_nxt_s;
  logic                   rise_r;
  logic                   rise_nxt_s;
  logic                   btn_s;

  // Shift the raw level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  assign btn_s = sync_r[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    db_nxt_s   = db_r;
    rise_nxt_s = 1'b0;
    if (btn_s == db_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s  = '0;
      db_nxt_s   = btn_s;
      rise_nxt_s = btn_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Debounce state and press pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      db_r   <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      db_r   <= db_nxt_s;
      rise_r <= rise_nxt_s;
    end
  end

  assign db   = db_r;
  assign rise = rise_r;

endmodule

// File: rtl/mode_input_conditioner_chk.sv
// Runtime checks on the conditioner outputs: the selector stays a legal mode and
// every change pulse coincides with an actual selector update.
module mode_input_conditioner_chk
  import types_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  input opr_mode_t SELECTOR,
  input logic      MODE_CHANGED
);

  a_selector_legal : assert property (@(posedge clk) disable iff (!rst_n)
    SELECTOR inside {ADD, SUB, LAND, LOR, LXOR, SLT});

  a_change_means_update : assert property (@(posedge clk) disable iff (!rst_n)
    MODE_CHANGED |-> (SELECTOR != $past(SELECTOR)));

endmodule

// File: rtl/mode_input_conditioner.sv
// Board input front end: synchronizes the switch bank and turns debounced next/prev
// button presses into registered steps through the operation modes.
module mode_input_conditioner
  import types_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      BTN_NEXT,
  input  logic      BTN_PREV,
  input  word_t     SW_IN,
  output opr_mode_t SELECTOR,
  output word_t     SW,
  output logic      MODE_CHANGED
);

  word_t     sw_sync_r [SYNC_STAGES];
  opr_mode_t sel_r;
  opr_mode_t sel_nxt_s;
  logic      chg_r;
  logic      chg_nxt_s;
  logic      next_rise_s;
  logic      prev_rise_s;
  logic      next_db_s;
  logic      prev_db_s;
  logic      unused_db_s;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (BTN_NEXT),
    .db    (next_db_s),
    .rise  (next_rise_s)
  );

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_db_prev (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (BTN_PREV),
    .db    (prev_db_s),
    .rise  (prev_rise_s)
  );

  // Debounced levels are only consumed as press pulses here.
  assign unused_db_s = next_db_s ^ prev_db_s;

  // Per-bit switch synchronizer; switches are level-only so no debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= '0;
      end
    end else begin
      sw_sync_r[0] <= SW_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync_r[i] <= sw_sync_r[i-1];
      end
    end
  end

  // Step selection; simultaneous presses cancel.
  always_comb begin
    sel_nxt_s = sel_r;
    chg_nxt_s = 1'b0;
    case ({next_rise_s, prev_rise_s})
      2'b10: begin
        sel_nxt_s = opr_mode_next(sel_r);
        chg_nxt_s = 1'b1;
      end
      2'b01: begin
        sel_nxt_s = opr_mode_prev(sel_r);
        chg_nxt_s = 1'b1;
      end
      default: begin
        sel_nxt_s = sel_r;
        chg_nxt_s = 1'b0;
      end
    endcase
  end

  // Mode register and its change strobe update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= OPR_MODE_FIRST;
      chg_r <= 1'b0;
    end else begin
      sel_r <= sel_nxt_s;
      chg_r <= chg_nxt_s;
    end
  end

  assign SELECTOR     = sel_r;
  assign SW           = sw_sync_r[SYNC_STAGES-1];
  assign MODE_CHANGED = chg_r;

  mode_input_conditioner_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .SELECTOR     (sel_r),
    .MODE_CHANGED (chg_r)
  );

endmodule

// File: tb/tb_mode_input_conditioner.sv
// Directed bench for mode_input_conditioner with DB_CYCLES=4, SYNC_STAGES=2.
module tb_mode_input_conditioner;
  import types_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      btn_next;
  logic      btn_prev;
  word_t     sw_in;
  opr_mode_t selector;
  word_t     sw;
  logic      mode_changed;

  int n_assert = 0;
  int n_fail   = 0;

  mode_input_conditioner #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BTN_NEXT     (btn_next),
    .BTN_PREV     (btn_prev),
    .SW_IN        (sw_in),
    .SELECTOR     (selector),
    .SW           (sw),
    .MODE_CHANGED (mode_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance n edges, requiring MODE_CHANGED low after each.
  task automatic step_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk(tag, {15'd0, mode_changed}, 16'd0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    sw_in    = 16'h0000;

    #2;
    chk("rst_sel", {13'd0, selector}, {13'd0, ADD});
    chk("rst_sw", sw, 16'h0000);
    chk("rst_mc", {15'd0, mode_changed}, 16'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Switch synchronizer: two edges of latency, nothing else moves.
    sw_in = 16'hA5A5;
    step(1);
    chk("sw_edge1", sw, 16'h0000);
    step(1);
    chk("sw_edge2", sw, 16'hA5A5);
    chk("sw_sel", {13'd0, selector}, {13'd0, ADD});
    chk("sw_mc", {15'd0, mode_changed}, 16'd0);

    // Clean next press held 20 cycles: single step on edge 7.
    btn_next = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("next_mc", {15'd0, mode_changed}, (k == 7) ? 16'd1 : 16'd0);
      if (k == 6) chk("next_sel_e6", {13'd0, selector}, {13'd0, ADD});
      if (k == 7) chk("next_sel_e7", {13'd0, selector}, {13'd0, SUB});
    end
    chk("next_held_sel", {13'd0, selector}, {13'd0, SUB});
    btn_next = 1'b0;
    step_quiet("next_release_mc", 10);
    chk("next_release_sel", {13'd0, selector}, {13'd0, SUB});

    // 3-cycle glitch followed by per-cycle bouncing.
    btn_next = 1'b1;
    step_quiet("glitch_mc", 3);
    btn_next = 1'b0;
    step_quiet("glitch_mc", 1);
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      step_quiet("bounce_mc", 1);
    end
    btn_next = 1'b0;
    step_quiet("bounce_tail_mc", 8);
    chk("bounce_sel", {13'd0, selector}, {13'd0, SUB});

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", {13'd0, selector}, {13'd0, ADD});
    chk("arst_sw", sw, 16'h0000);
    chk("arst_mc", {15'd0, mode_changed}, 16'd0);
    step(1);
    rst_n = 1'b1;

    // Prev from first mode wraps to last.
    btn_prev = 1'b1;
    step(6);
    chk("prev_sel_e6", {13'd0, selector}, {13'd0, ADD});
    chk("prev_sw_resync", sw, 16'hA5A5);
    step(1);
    chk("prev_sel_e7", {13'd0, selector}, {13'd0, SLT});
    chk("prev_mc_e7", {15'd0, mode_changed}, 16'd1);
    step(1);
    chk("prev_mc_e8", {15'd0, mode_changed}, 16'd0);
    btn_prev = 1'b0;
    step_quiet("prev_release_mc", 8);

    // Simultaneous next+prev: presses cancel, then releases are quiet too.
    btn_next = 1'b1;
    btn_prev = 1'b1;
    step_quiet("both_mc", 12);
    chk("both_sel", {13'd0, selector}, {13'd0, SLT});
    btn_next = 1'b0;
    btn_prev = 1'b0;
    step_quiet("both_release_mc", 8);
    chk("both_release_sel", {13'd0, selector}, {13'd0, SLT});

    // Next from last mode wraps to first.
    btn_next = 1'b1;
    step(7);
    chk("wrap_sel", {13'd0, selector}, {13'd0, ADD});
    chk("wrap_mc", {15'd0, mode_changed}, 16'd1);
    btn_next = 1'b0;
    step_quiet("wrap_release_mc", 8);

    // Reset while prev is two cycles into debounce; released during reset.
    btn_prev = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    step(1);
    btn_prev = 1'b0;
    step(1);
    rst_n = 1'b1;
    step_quiet("rstdb_mc", 12);
    chk("rstdb_sel", {13'd0, selector}, {13'd0, ADD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
